// File: rtl/rf_write_arbiter_if.sv
// Writeback request ports and register-file write port bundle
// for the two-requester register-file write arbiter.
interface rf_write_arbiter_if #(
  parameter int W = 32
);

  logic         req0_valid;
  logic [3:0]   req0_addr;
  logic [W-1:0] req0_data;
  logic         req0_ready;

  logic         req1_valid;
  logic [3:0]   req1_addr;
  logic [W-1:0] req1_data;
  logic         req1_ready;

  logic         rf_we;
  logic [3:0]   rf_a3;
  logic [W-1:0] rf_wd;

  logic [14:0]  pending;
  logic         pc_drop;
  logic         grant_last;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_a3, rf_wd,
    input  pending, pc_drop, grant_last
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_a3, rf_wd,
    output pending, pc_drop, grant_last
  );

endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// ALU (port 0) and load (port 1) writeback, each with a 2-entry FIFO.
module rf_write_arbiter #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  rf_write_arbiter_if.slave bus
);

  logic [1:0]             in_valid;
  logic [1:0][3:0]        in_addr;
  logic [1:0][W-1:0]      in_data;

  logic [1:0][1:0][3:0]   addr_q, addr_d;
  logic [1:0][1:0][W-1:0] data_q, data_d;
  logic [1:0][1:0]        cnt_q, cnt_d;
  logic [1:0]             rd_q, rd_d;
  logic [1:0]             wr_q, wr_d;

  logic                   we_q, we_d;
  logic                   drop_q, drop_d;
  logic                   gl_q, gl_d;
  logic [3:0]             a3_q, a3_d;
  logic [W-1:0]           wd_q, wd_d;

  logic [1:0]             ready;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             nonempty;
  logic [1:0][3:0]        head_addr;
  logic [1:0][W-1:0]      head_data;
  logic                   win;
  logic [1:0][1:0]        ent_v;
  logic [14:0]            pend;

  assign in_valid = {bus.req1_valid, bus.req0_valid};
  assign in_addr  = {bus.req1_addr, bus.req0_addr};
  assign in_data  = {bus.req1_data, bus.req0_data};

  // ready looks only at the registered count: a full
  // queue never accepts, even if it pops this cycle
  always_comb begin
    ready     = '0;
    push      = '0;
    nonempty  = '0;
    head_addr = '0;
    head_data = '0;
    for (int p = 0; p < 2; p++) begin
      ready[p]     = (cnt_q[p] < 2'd2) && !flush;
      push[p]      = in_valid[p] && ready[p];
      nonempty[p]  = cnt_q[p] != 2'd0;
      head_addr[p] = addr_q[p][rd_q[p]];
      head_data[p] = data_q[p][rd_q[p]];
    end
  end

  // on a tie the port that did not win last time goes
  always_comb begin
    pop = '0;
    if (!flush) begin
      unique case (nonempty)
        2'b01:   pop = 2'b01;
        2'b10:   pop = 2'b10;
        2'b11:   pop = gl_q ? 2'b01 : 2'b10;
        default: pop = '0;
      endcase
    end
    win = pop[1];
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        addr_d[p][wr_q[p]] = in_addr[p];
        data_d[p][wr_q[p]] = in_data[p];
        wr_d[p]            = ~wr_q[p];
      end
      if (pop[p]) begin
        rd_d[p] = ~rd_q[p];
      end
      cnt_d[p] = cnt_q[p]
               + {1'b0, push[p]}
               - {1'b0, pop[p]};
    end
    if (flush) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end
  end

  // r15 is the PC: popped like any entry but never written
  always_comb begin
    we_d   = 1'b0;
    drop_d = 1'b0;
    a3_d   = a3_q;
    wd_d   = wd_q;
    gl_d   = gl_q;
    if (|pop) begin
      gl_d = win;
      a3_d = head_addr[win];
      wd_d = head_data[win];
      if (head_addr[win] == 4'hF) begin
        drop_d = 1'b1;
      end else begin
        we_d = 1'b1;
      end
    end
  end

  always_comb begin
    ent_v = '0;
    pend  = '0;
    for (int p = 0; p < 2; p++) begin
      ent_v[p][0] = (cnt_q[p] == 2'd2)
                 || (cnt_q[p] == 2'd1 && !rd_q[p]);
      ent_v[p][1] = (cnt_q[p] == 2'd2)
                 || (cnt_q[p] == 2'd1 && rd_q[p]);
      for (int e = 0; e < 2; e++) begin
        if (ent_v[p][e] && addr_q[p][e] != 4'hF) begin
          pend[addr_q[p][e]] = 1'b1;
        end
      end
    end
    if (we_q && a3_q != 4'hF) begin
      pend[a3_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      we_q   <= 1'b0;
      drop_q <= 1'b0;
      gl_q   <= 1'b1;
      a3_q   <= '0;
      wd_q   <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      we_q   <= we_d;
      drop_q <= drop_d;
      gl_q   <= gl_d;
      a3_q   <= a3_d;
      wd_q   <= wd_d;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rf_we      = we_q;
  assign bus.rf_a3      = a3_q;
  assign bus.rf_wd      = wd_q;
  assign bus.pending    = pend;
  assign bus.pc_drop    = drop_q;
  assign bus.grant_last = gl_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (WE / A3 / data) between two writeback requesters: port 0 (ALU result) and port 1 (load/memory result). Each requester has a 2-entry queue with valid/ready handshake. A round-robin arbiter drains one entry per cycle into a registered output stage that drives the register file. A per-register pending bitmap lets decode stall on registers with queued writes.

## Interface
- W, 32, data width of register values and write data.
- DEPTH, 2, entries per requester queue (fixed at 2; count width 2 bits).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all queued and staged writes.
- req0_valid  in  1  port 0 (ALU) write request.
- req0_addr  in  4  port 0 destination register.
- req0_data  in  W  port 0 write data.
- req0_ready  out  1  port 0 queue can accept.
- req1_valid  in  1  port 1 (load) write request.
- req1_addr  in  4  port 1 destination register.
- req1_data  in  W  port 1 write data.
- req1_ready  out  1  port 1 queue can accept.
- rf_we  out  1  register-file write enable (WE).
- rf_a3  out  4  register-file write address (A3).
- rf_wd  out  W  register-file write data.
- pending  out  15  bit r set while any queued/staged write targets register r (0–14).
- pc_drop  out  1  one-cycle pulse: a write to address 15 was discarded.
- grant_last  out  1  port that won the most recent arbitration.

## Operation
- Handshake: transfer on rising clk when reqN_valid && reqN_ready. Data/addr captured into queue N tail. Valid without ready: requester holds values stable; no capture.
- reqN_ready = (countN < 2) && !flush. Depends only on registered count, never on same-cycle pop (no full-queue pass-through).
- Queues are FIFO; push and pop in the same cycle allowed (count unchanged; non-full queue only).
- Arbitration each cycle over queue heads:
  - one head non-empty: that port wins.
  - both non-empty: port != grant_last wins; grant_last updates to winner.
  - none: no pop; output stage loads invalid.
- Winner head popped at the edge; output stage loads {we=1, addr, data}.
- Address 15 (PC, not in the register file): head popped normally, output stage loads we=0, pc_drop=1 for that cycle. grant_last still updates.
- pending[r] = OR over valid queue entries (both ports, up to 4) and staged output with we=1 whose addr == r. Combinational from state.
- Same register written by both ports: order is arbitration order only; no cross-port ordering guaranteed.
- flush: at the edge, both counts → 0, output stage → invalid (rf_we=0), pc_drop=0; grant_last retained. Requests presented during flush are not accepted (ready=0).

## Timing
- Reset (async, reset=0): counts 0, rf_we 0, rf_a3 0, rf_wd 0, pc_drop 0, grant_last 1 (port 0 wins first tie), pending 0, req0_ready/req1_ready 1 after release.
- Latency: request accepted at edge k into empty queue, no contention → rf_we=1 during cycle after edge k+1; register file writes at edge k+2.
- rf_we high exactly one cycle per popped entry; back-to-back writes allowed every cycle.
- Throughput: 1 write/cycle total; with both ports saturated, strict alternation 0,1,0,1.
- pending[r] asserts the cycle after acceptance, deasserts the cycle after the register-file write edge.
- Reset mid-operation: all queued writes lost; no partial write (rf_we forced 0 asynchronously).

## Test plan
- Reset then single req0 {addr 3, data 0x25978903} accepted at edge 1 → rf_we=1, rf_a3=3, rf_wd=0x25978903 after edge 2 for one cycle; pending[3] high cycles 1–2.
- Both ports valid every cycle, addrs 1/2 → rf_a3 sequence 1,2,1,2…; port 0 first after reset; grant_last toggles.
- Hold req1_valid with no drain contention from port 0 flooding: third push stalls → req1_ready=0 when count1=2; reasserts cycle after a pop.
- req0 addr 15 data 0x34862389 → pc_drop pulses one cycle, rf_we stays 0, pending unchanged.
- Fill both queues (4 entries), assert flush one cycle → rf_we=0 next cycle, pending=0, readies 0 during flush, 1 after.
- Assert reset low while rf_we=1 → rf_we drops immediately, no write; after release queues empty, req ports ready.
